// File: rtl/sdram_pkg.sv
// Shared types and constants for the two-port SDRAM request arbiter.
package sdram_pkg;

  localparam int DEF_AW = 24;
  localparam int DEF_DW = 16;

  localparam logic PORT_IFETCH = 1'b0;
  localparam logic PORT_DATA   = 1'b1;

  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_ISSUE     = 2'd1,
    ST_WAIT_ACK  = 2'd2,
    ST_WAIT_DONE = 2'd3
  } arb_state_e;

  // Round-robin pick: a lone full buffer wins; on a tie the port that was
  // not granted last time wins.
  function automatic logic pick_grant(input logic full0, input logic full1,
                                      input logic last_grant);
    logic g;
    if (full0 && full1) g = ~last_grant;
    else if (full1)     g = PORT_DATA;
    else                g = PORT_IFETCH;
    return g;
  endfunction

endpackage

// File: rtl/sdram_arb_slot.sv
// One-entry request buffer for a single arbiter port: latches a request,
// reports occupancy, and returns read data with a one-cycle ready pulse.
module sdram_arb_slot
  import sdram_pkg::*;
#(
  parameter int AW = DEF_AW,
  parameter int DW = DEF_DW
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [AW-1:0] addr_i,
  input  logic [DW-1:0] data_i,
  input  logic          read_req_i,
  input  logic          write_req_i,
  input  logic          wr_done_i,
  input  logic          rd_done_i,
  input  logic [DW-1:0] rd_data_i,
  output logic [AW-1:0] buf_addr_o,
  output logic [DW-1:0] buf_data_o,
  output logic          buf_is_write_o,
  output logic          busy_o,
  output logic [DW-1:0] data_out_o,
  output logic          read_ready_o
);

  logic          busy_q;
  logic          is_write_q;
  logic          read_ready_q;
  logic [AW-1:0] addr_q;
  logic [DW-1:0] data_q;
  logic [DW-1:0] data_out_q;
  logic          accept;

  // New requests are taken only into an empty buffer; busy requests are dropped.
  assign accept = (read_req_i | write_req_i) & ~busy_q;

  // Buffer occupancy, latched request fields and read-return registers.
  always_ff @(posedge clk or posedge rst) begin
    // NOTE: the payload registers are reset too, so every port reads 0 out of reset.
    if (rst) begin
      busy_q       <= 1'b0;
      is_write_q   <= 1'b0;
      read_ready_q <= 1'b0;
      addr_q       <= '0;
      data_q       <= '0;
      data_out_q   <= '0;
    end else begin
      // NOTE: non-blocking assignments so every register sees pre-edge values.
      read_ready_q <= 1'b0;
      if (accept) begin
        busy_q     <= 1'b1;
        addr_q     <= addr_i;
        data_q     <= data_i;
        is_write_q <= write_req_i & ~read_req_i;  // read wins when both strobes are high
      end else if (wr_done_i) begin
        busy_q <= 1'b0;
      end else if (rd_done_i) begin
        busy_q       <= 1'b0;
        data_out_q   <= rd_data_i;
        read_ready_q <= 1'b1;
      end
    end
  end

  assign buf_addr_o     = addr_q;
  assign buf_data_o     = data_q;
  assign buf_is_write_o = is_write_q;
  assign busy_o         = busy_q;
  assign data_out_o     = data_out_q;
  assign read_ready_o   = read_ready_q;

endmodule

// File: rtl/sdram_arbiter.sv
// Two-port round-robin arbiter in front of the SDRAM controller request port.
// Port 0 is instruction fetch, port 1 is data; one transaction in flight.
module sdram_arbiter
  import sdram_pkg::*;
#(
  parameter int AW = DEF_AW,
  parameter int DW = DEF_DW
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [AW-1:0] p0_addr,
  input  logic [DW-1:0] p0_data_in,
  input  logic          p0_read_req,
  input  logic          p0_write_req,
  output logic [DW-1:0] p0_data_out,
  output logic          p0_busy,
  output logic          p0_read_ready,
  input  logic [AW-1:0] p1_addr,
  input  logic [DW-1:0] p1_data_in,
  input  logic          p1_read_req,
  input  logic          p1_write_req,
  output logic [DW-1:0] p1_data_out,
  output logic          p1_busy,
  output logic          p1_read_ready,
  output logic [AW-1:0] m_addr,
  output logic [DW-1:0] m_data_in,
  output logic          m_read_req,
  output logic          m_write_req,
  input  logic [DW-1:0] m_data_out,
  input  logic          m_busy,
  input  logic          m_read_ready
);

  arb_state_e    state_q;
  logic          grant_q;
  logic          last_grant_q;
  logic          is_write_q;
  logic          rr_prev_q;
  logic          m_read_req_q;
  logic          m_write_req_q;
  logic [AW-1:0] m_addr_q;
  logic [DW-1:0] m_data_q;

  logic [AW-1:0] s0_addr, s1_addr;
  logic [DW-1:0] s0_data, s1_data;
  logic          s0_is_write, s1_is_write;

  logic          grant_d;
  logic [AW-1:0] sel_addr;
  logic [DW-1:0] sel_data;
  logic          sel_is_write;
  logic          wr_done, rd_done;
  logic          wr_done0, wr_done1, rd_done0, rd_done1;

  assign grant_d      = pick_grant(p0_busy, p1_busy, last_grant_q);
  assign sel_addr     = (grant_d == PORT_DATA) ? s1_addr     : s0_addr;
  assign sel_data     = (grant_d == PORT_DATA) ? s1_data     : s0_data;
  assign sel_is_write = (grant_d == PORT_DATA) ? s1_is_write : s0_is_write;

  // Writes finish when the controller drops busy; reads finish on a rising
  // edge of read_ready, so a level left high from earlier is not mistaken.
  assign wr_done  = (state_q == ST_WAIT_DONE) & is_write_q & ~m_busy;
  assign rd_done  = (state_q == ST_WAIT_DONE) & ~is_write_q & m_read_ready & ~rr_prev_q;
  assign wr_done0 = wr_done & (grant_q == PORT_IFETCH);
  assign wr_done1 = wr_done & (grant_q == PORT_DATA);
  assign rd_done0 = rd_done & (grant_q == PORT_IFETCH);
  assign rd_done1 = rd_done & (grant_q == PORT_DATA);

  sdram_arb_slot #(.AW(AW), .DW(DW)) u_slot0 (
    .clk            (clk),
    .rst            (rst),
    .addr_i         (p0_addr),
    .data_i         (p0_data_in),
    .read_req_i     (p0_read_req),
    .write_req_i    (p0_write_req),
    .wr_done_i      (wr_done0),
    .rd_done_i      (rd_done0),
    .rd_data_i      (m_data_out),
    .buf_addr_o     (s0_addr),
    .buf_data_o     (s0_data),
    .buf_is_write_o (s0_is_write),
    .busy_o         (p0_busy),
    .data_out_o     (p0_data_out),
    .read_ready_o   (p0_read_ready)
  );

  sdram_arb_slot #(.AW(AW), .DW(DW)) u_slot1 (
    .clk            (clk),
    .rst            (rst),
    .addr_i         (p1_addr),
    .data_i         (p1_data_in),
    .read_req_i     (p1_read_req),
    .write_req_i    (p1_write_req),
    .wr_done_i      (wr_done1),
    .rd_done_i      (rd_done1),
    .rd_data_i      (m_data_out),
    .buf_addr_o     (s1_addr),
    .buf_data_o     (s1_data),
    .buf_is_write_o (s1_is_write),
    .busy_o         (p1_busy),
    .data_out_o     (p1_data_out),
    .read_ready_o   (p1_read_ready)
  );

  // Transaction FSM: grant, one-cycle issue strobe, then track the controller handshake.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= ST_IDLE;
      grant_q       <= PORT_IFETCH;
      last_grant_q  <= PORT_DATA;
      is_write_q    <= 1'b0;
      rr_prev_q     <= 1'b0;
      m_read_req_q  <= 1'b0;
      m_write_req_q <= 1'b0;
      m_addr_q      <= '0;
      m_data_q      <= '0;
    end else begin
      rr_prev_q     <= m_read_ready;
      m_read_req_q  <= 1'b0;
      m_write_req_q <= 1'b0;
      unique case (state_q)
        ST_IDLE: begin
          if ((p0_busy || p1_busy) && !m_busy) begin
            grant_q       <= grant_d;
            last_grant_q  <= grant_d;
            is_write_q    <= sel_is_write;
            m_addr_q      <= sel_addr;
            m_data_q      <= sel_data;
            m_read_req_q  <= ~sel_is_write;
            m_write_req_q <= sel_is_write;
            state_q       <= ST_ISSUE;
          end
        end
        ST_ISSUE:     state_q <= ST_WAIT_ACK;
        ST_WAIT_ACK:  if (m_busy) state_q <= ST_WAIT_DONE;
        ST_WAIT_DONE: if (wr_done || rd_done) state_q <= ST_IDLE;
        default:      state_q <= ST_IDLE;
      endcase
    end
  end

  assign m_addr      = m_addr_q;
  assign m_data_in   = m_data_q;
  assign m_read_req  = m_read_req_q;
  assign m_write_req = m_write_req_q;

endmodule
